// File: rtl/demux_1x16_seq_if.sv
// Bus bundle for the registered 1-to-16 demultiplexer: write-side controls in,
// held lanes, strobe, pointer and frame snapshot out.
interface demux_1x16_seq_if #(
    parameter int OUT_LENGTH = 16,
    parameter int SEL_LENGTH = 4
);
    logic                  clr;
    logic                  auto_mode;
    logic                  in_valid;
    logic                  in_bit;
    logic [SEL_LENGTH-1:0] sel;
    logic [OUT_LENGTH-1:0] out;
    logic [OUT_LENGTH-1:0] lane_strobe;
    logic [SEL_LENGTH-1:0] ptr;
    logic                  frame_done;
    logic [OUT_LENGTH-1:0] frame_out;

    modport master (
        output clr, auto_mode, in_valid, in_bit, sel,
        input  out, lane_strobe, ptr, frame_done, frame_out
    );

    modport slave (
        input  clr, auto_mode, in_valid, in_bit, sel,
        output out, lane_strobe, ptr, frame_done, frame_out
    );
endinterface

// File: rtl/demux_1x16_seq.sv
// Registered 1-to-16 demultiplexer with manual (sel) and auto (pointer) lane
// addressing; auto mode assembles 16 consecutive bits into a flagged frame.
module demux_1x16_seq #(
    parameter int OUT_LENGTH = 16,
    parameter int SEL_LENGTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    demux_1x16_seq_if.slave     bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [SEL_LENGTH-1:0] LAST_LANE = SEL_LENGTH'(OUT_LENGTH - 1);
    localparam logic [SEL_LENGTH-1:0] LANE_ZERO = {SEL_LENGTH{1'b0}};

    state_t                r_state;
    state_t                w_state_nxt;
    state_t                w_base_state;
    logic                  r_auto_q;
    logic [OUT_LENGTH-1:0] r_out;
    logic [OUT_LENGTH-1:0] w_out_nxt;
    logic [OUT_LENGTH-1:0] r_strobe;
    logic [OUT_LENGTH-1:0] w_strobe_nxt;
    logic [OUT_LENGTH-1:0] r_frame;
    logic [OUT_LENGTH-1:0] w_frame_nxt;
    logic [SEL_LENGTH-1:0] r_ptr;
    logic [SEL_LENGTH-1:0] w_ptr_nxt;
    logic [SEL_LENGTH-1:0] w_base_ptr;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_mode_chg;

    function automatic logic [OUT_LENGTH-1:0] f_onehot(input logic [SEL_LENGTH-1:0] idx);
        f_onehot = {{(OUT_LENGTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next-state and next-output decode: clr, then mode change, then the write.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_strobe_nxt = {OUT_LENGTH{1'b0}};
        w_frame_nxt  = r_frame;
        w_ptr_nxt    = r_ptr;
        w_done_nxt   = 1'b0;
        w_mode_chg   = (bus.auto_mode != r_auto_q);
        // A mode change restarts the pointer before this cycle's write is applied.
        w_base_ptr   = w_mode_chg ? LANE_ZERO : r_ptr;
        w_base_state = w_mode_chg ? ST_IDLE : r_state;

        if (bus.clr) begin
            w_out_nxt   = {OUT_LENGTH{1'b0}};
            w_ptr_nxt   = LANE_ZERO;
            w_state_nxt = ST_IDLE;
        end else begin
            w_ptr_nxt   = w_base_ptr;
            w_state_nxt = w_base_state;
            if (!bus.in_valid) begin
                w_strobe_nxt = {OUT_LENGTH{1'b0}};
            end else if (!bus.auto_mode) begin
                w_out_nxt[bus.sel] = bus.in_bit;
                w_strobe_nxt       = f_onehot(bus.sel);
            end else begin
                case (w_base_state)
                    ST_IDLE: begin
                        w_out_nxt[0] = bus.in_bit;
                        w_strobe_nxt = f_onehot(LANE_ZERO);
                        w_ptr_nxt    = SEL_LENGTH'(1);
                        w_state_nxt  = ST_FILL;
                    end
                    ST_FILL: begin
                        w_out_nxt[w_base_ptr] = bus.in_bit;
                        w_strobe_nxt          = f_onehot(w_base_ptr);
                        if (w_base_ptr == LAST_LANE) begin
                            w_ptr_nxt   = LANE_ZERO;
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                            w_frame_nxt = w_out_nxt;
                        end else begin
                            w_ptr_nxt   = w_base_ptr + SEL_LENGTH'(1);
                            w_state_nxt = ST_FILL;
                        end
                    end
                    default: begin
                        w_ptr_nxt   = LANE_ZERO;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_auto_q <= 1'b0;
            r_out    <= {OUT_LENGTH{1'b0}};
            r_strobe <= {OUT_LENGTH{1'b0}};
            r_frame  <= {OUT_LENGTH{1'b0}};
            r_ptr    <= LANE_ZERO;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_auto_q <= bus.auto_mode;
            r_out    <= w_out_nxt;
            r_strobe <= w_strobe_nxt;
            r_frame  <= w_frame_nxt;
            r_ptr    <= w_ptr_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.out         = r_out;
    assign bus.lane_strobe = r_strobe;
    assign bus.ptr         = r_ptr;
    assign bus.frame_done  = r_done;
    assign bus.frame_out   = r_frame;
endmodule

// File: tb/tb_demux_1x16_seq.sv
// Self-checking bench for demux_1x16_seq: reset, a vector table for the manual
// sweep, hand sequences for frame corner cases, then random traffic vs a model.
module tb_demux_1x16_seq;
    logic clk;
    logic rstn;
    int   n_total;
    int   n_pass;

    demux_1x16_seq_if #(.OUT_LENGTH(16), .SEL_LENGTH(4)) bus ();

    demux_1x16_seq #(.OUT_LENGTH(16), .SEL_LENGTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [3:0]  sel;
        logic        bit_v;
        logic [15:0] exp_out;
        logic [15:0] exp_strobe;
    } vec_t;

    vec_t vecs [17];

    // Reference model: lanes as a plain vector, pointer as a fill count.
    logic [15:0] m_out, m_strobe, m_frame;
    logic [3:0]  m_ptr;
    logic        m_done, m_prev_auto;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    task automatic model(input logic r, input logic c, input logic a, input logic v,
                         input logic b, input logic [3:0] s);
        logic [3:0] lane;
        if (!r) begin
            m_out = 16'h0000; m_strobe = 16'h0000; m_frame = 16'h0000;
            m_ptr = 4'd0; m_done = 1'b0; m_prev_auto = 1'b0;
            return;
        end
        m_strobe = 16'h0000;
        m_done   = 1'b0;
        if (a != m_prev_auto) m_ptr = 4'd0;
        m_prev_auto = a;
        if (c) begin
            m_out = 16'h0000;
            m_ptr = 4'd0;
            return;
        end
        if (v) begin
            lane          = a ? m_ptr : s;
            m_out[lane]   = b;
            m_strobe      = 16'h0001 << lane;
            if (a) begin
                m_ptr = m_ptr + 4'd1;
                if (lane == 4'd15) begin
                    m_done  = 1'b1;
                    m_frame = m_out;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic a, input logic v,
                        input logic b, input logic [3:0] s);
        rstn          = r;
        bus.clr       = c;
        bus.auto_mode = a;
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.sel       = s;
        @(posedge clk);
        model(r, c, a, v, b, s);
        #1;
        chk("out", bus.out, m_out);
        chk("lane_strobe", bus.lane_strobe, m_strobe);
        chk("ptr", {12'h000, bus.ptr}, {12'h000, m_ptr});
        chk("frame_done", {15'h0000, bus.frame_done}, {15'h0000, m_done});
        chk("frame_out", bus.frame_out, m_frame);
    endtask

    task automatic send_frame(input logic [15:0] pat);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b1, pat[i], 4'd0);
    endtask

    initial begin
        logic [15:0] pat;
        logic r_v, c_v, a_v;
        n_total = 0;
        n_pass  = 0;
        rstn    = 1'b0;
        a_v     = 1'b0;
        model(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Reset held two cycles while a write is offered.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
        chk("rst_out", bus.out, 16'h0000);
        chk("rst_strobe", bus.lane_strobe, 16'h0000);
        chk("rst_ptr", {12'h000, bus.ptr}, 16'h0000);
        chk("rst_done", {15'h0000, bus.frame_done}, 16'h0000);
        chk("rst_frame", bus.frame_out, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("post_rst_out", bus.out, 16'h0000);

        // Manual sweep table.
        for (int i = 0; i < 16; i++) begin
            vecs[i].sel        = 4'(i);
            vecs[i].bit_v      = 1'b1;
            vecs[i].exp_out    = 16'((32'h1 << (i + 1)) - 32'h1);
            vecs[i].exp_strobe = 16'(32'h1 << i);
        end
        vecs[16] = '{sel: 4'd5, bit_v: 1'b0, exp_out: 16'hFFDF, exp_strobe: 16'h0020};
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, vecs[i].bit_v, vecs[i].sel);
            chk("tbl_out", bus.out, vecs[i].exp_out);
            chk("tbl_strobe", bus.lane_strobe, vecs[i].exp_strobe);
            chk("tbl_ptr", {12'h000, bus.ptr}, 16'h0000);
        end

        // Auto frame, then no-bubble next write.
        send_frame(16'hA5C3);
        chk("auto_done", {15'h0000, bus.frame_done}, 16'h0001);
        chk("auto_frame", bus.frame_out, 16'hA5C3);
        chk("auto_ptr", {12'h000, bus.ptr}, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        chk("b2b_strobe", bus.lane_strobe, 16'h0001);
        chk("b2b_ptr", {12'h000, bus.ptr}, 16'h0001);
        chk("b2b_done", {15'h0000, bus.frame_done}, 16'h0000);

        // Gaps after bits 4 and 11.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pat = 16'h5A3C;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, pat[i], 4'd0);
            if (i == 4 || i == 11) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
                    chk("gap_ptr", {12'h000, bus.ptr}, 16'(i + 1));
                    chk("gap_done", {15'h0000, bus.frame_done}, 16'h0000);
                end
            end
        end
        chk("gap_frame_done", {15'h0000, bus.frame_done}, 16'h0001);
        chk("gap_frame", bus.frame_out, 16'h5A3C);
        send_frame(16'h1234);
        chk("second_frame", bus.frame_out, 16'h1234);

        // clr mid-frame drops the concurrent write.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
        chk("clr_out", bus.out, 16'h0000);
        chk("clr_ptr", {12'h000, bus.ptr}, 16'h0000);
        chk("clr_strobe", bus.lane_strobe, 16'h0000);
        chk("clr_frame_hold", bus.frame_out, 16'h1234);
        send_frame(16'hBEEF);
        chk("post_clr_frame", bus.frame_out, 16'hBEEF);

        // Mode switch mid-frame, then reset at ptr=12.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        chk("sw_ptr", {12'h000, bus.ptr}, 16'h0000);
        chk("sw_out3", {15'h0000, bus.out[3]}, 16'h0001);
        chk("sw_strobe", bus.lane_strobe, 16'h0008);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
        chk("ret_strobe", bus.lane_strobe, 16'h0001);
        chk("ret_ptr", {12'h000, bus.ptr}, 16'h0001);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        chk("pre_rst_ptr", {12'h000, bus.ptr}, 16'h000C);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        chk("midrst_done", {15'h0000, bus.frame_done}, 16'h0000);
        chk("midrst_out", bus.out, 16'h0000);
        chk("midrst_frame", bus.frame_out, 16'h0000);
        chk("midrst_ptr", {12'h000, bus.ptr}, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r_v = ($urandom_range(0, 99) != 0);
            c_v = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) a_v = ~a_v;
            step(r_v, c_v, a_v, ($urandom_range(0, 3) != 0), 1'($urandom),
                 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
